// File: rtl/rob.sv
// Reorder buffer: allocates 1-4 slots per cycle and accepts out-of-order writeback on two ports.
// Retires up to two completed entries per cycle to the register file, in program order.
module rob #(
   parameter int ROB_DEPTHLOG2 = 4
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               reserve,
   input  logic [1:0]                         reserve_count,
   input  logic [3:0][4:0]                    dest_reg,
   input  logic [3:0]                         dest_reg_valid,
   output logic [3:0][ROB_DEPTHLOG2-1:0]      reserved_slots,
   output logic                               rob_full,
   input  logic [1:0]                         wb_valid,
   input  logic [1:0][ROB_DEPTHLOG2-1:0]      wb_slot,
   input  logic [1:0][31:0]                   wb_data,
   output logic [1:0]                         rf_we,
   output logic [1:0][4:0]                    rf_waddr,
   output logic [1:0][31:0]                   rf_wdata,
   input  logic                               flush
);

   localparam int L     = ROB_DEPTHLOG2;
   localparam int DEPTH = 1 << L;
   localparam int CNT_W = L + 1;

   typedef logic [L-1:0] idx_t;

   idx_t             head;
   idx_t             tail;
   logic [CNT_W-1:0] count;

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] done;
   logic [DEPTH-1:0] dreg_v;
   logic [4:0]       dreg [DEPTH];
   logic [31:0]      data [DEPTH];

   logic             alloc_ok;
   logic [2:0]       n_alloc;
   idx_t             head1;
   logic             ret0;
   logic             ret1;
   logic [1:0]       n_retire;

   // Slot indices come straight from the registered tail so decode sees them in the request cycle.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         reserved_slots[k] = tail + idx_t'(k);
      end
   end

   assign rob_full = (count > CNT_W'(DEPTH - 4));
   assign alloc_ok = reserve & ~rob_full;
   assign n_alloc  = alloc_ok ? ({1'b0, reserve_count} + 3'd1) : 3'd0;

   // Retire looks only at registered done bits, so a writeback becomes retirable one cycle later.
   assign head1    = head + idx_t'(1);
   assign ret0     = busy[head] & done[head];
   assign ret1     = ret0 & busy[head1] & done[head1];
   assign n_retire = {1'b0, ret0} + {1'b0, ret1};

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         busy  <= '0;
         done  <= '0;
         rf_we <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (wb_valid[p] && busy[wb_slot[p]]) begin
               done[wb_slot[p]] <= 1'b1;
            end
         end
         if (ret0) begin
            busy[head] <= 1'b0;
            done[head] <= 1'b0;
         end
         if (ret1) begin
            busy[head1] <= 1'b0;
            done[head1] <= 1'b0;
         end
         for (int k = 0; k < 4; k++) begin
            if (alloc_ok && (2'(k) <= reserve_count)) begin
               busy[reserved_slots[k]] <= 1'b1;
               done[reserved_slots[k]] <= 1'b0;
            end
         end
         tail     <= tail + idx_t'(n_alloc);
         head     <= head + idx_t'(n_retire);
         count    <= count + CNT_W'(n_alloc) - CNT_W'(n_retire);
         rf_we[0] <= ret0 & dreg_v[head];
         rf_we[1] <= ret1 & dreg_v[head1];
      end
   end

   // Payload storage needs no reset: it is only consumed when the matching busy/done bits say so.
   always_ff @(posedge clock) begin
      for (int p = 0; p < 2; p++) begin
         if (wb_valid[p] && busy[wb_slot[p]]) begin
            data[wb_slot[p]] <= wb_data[p];
         end
      end
      for (int k = 0; k < 4; k++) begin
         if (alloc_ok && (2'(k) <= reserve_count)) begin
            dreg[reserved_slots[k]]   <= dest_reg[k];
            dreg_v[reserved_slots[k]] <= dest_reg_valid[k];
         end
      end
      rf_waddr[0] <= dreg[head];
      rf_wdata[0] <= data[head];
      rf_waddr[1] <= dreg[head1];
      rf_wdata[1] <= data[head1];
   end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: retire traffic is checked by a scoreboard monitor,
// slot indices / full flag / write enables by direct checks in the stimulus thread.
module tb_rob;

   logic             clock;
   logic             reset;
   logic             reserve;
   logic [1:0]       reserve_count;
   logic [3:0][4:0]  dest_reg;
   logic [3:0]       dest_reg_valid;
   logic [3:0][3:0]  reserved_slots;
   logic             rob_full;
   logic [1:0]       wb_valid;
   logic [1:0][3:0]  wb_slot;
   logic [1:0][31:0] wb_data;
   logic [1:0]       rf_we;
   logic [1:0][4:0]  rf_waddr;
   logic [1:0][31:0] rf_wdata;
   logic             flush;

   int vectors = 0;
   int miscompares = 0;
   logic [36:0] exp_q[$];

   rob #(.ROB_DEPTHLOG2(4)) dut (
      .clock(clock), .reset(reset), .reserve(reserve), .reserve_count(reserve_count),
      .dest_reg(dest_reg), .dest_reg_valid(dest_reg_valid), .reserved_slots(reserved_slots),
      .rob_full(rob_full), .wb_valid(wb_valid), .wb_slot(wb_slot), .wb_data(wb_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flush(flush)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task tick;
      @(posedge clock);
      #1;
   endtask

   task idle;
      reserve        = 1'b0;
      reserve_count  = 2'd0;
      dest_reg       = '0;
      dest_reg_valid = '0;
      wb_valid       = '0;
      wb_slot        = '0;
      wb_data        = '0;
      flush          = 1'b0;
   endtask

   task checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task doReset;
      idle();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   // Issues one allocation group; checks the offered slots against the expected tail first.
   task applyStimulus(input int n, input logic [3:0][4:0] regs, input logic [3:0] vld,
                      input logic [3:0] base);
      logic [15:0] exp_slots;
      exp_slots      = {base + 4'd3, base + 4'd2, base + 4'd1, base};
      reserve        = 1'b1;
      reserve_count  = 2'(n - 1);
      dest_reg       = regs;
      dest_reg_valid = vld;
      checkOutput("reserved_slots", 64'(reserved_slots), 64'(exp_slots));
      tick();
      reserve = 1'b0;
   endtask

   task wb1(input logic [3:0] s, input logic [31:0] d);
      wb_valid   = 2'b01;
      wb_slot[0] = s;
      wb_data[0] = d;
      tick();
      wb_valid = '0;
   endtask

   task wb2(input logic [3:0] s0, input logic [31:0] d0, input logic [3:0] s1, input logic [31:0] d1);
      wb_valid   = 2'b11;
      wb_slot[0] = s0;
      wb_data[0] = d0;
      wb_slot[1] = s1;
      wb_data[1] = d1;
      tick();
      wb_valid = '0;
   endtask

   task expectRetire(input logic [4:0] r, input logic [31:0] d);
      exp_q.push_back({r, d});
   endtask

   // Monitor: every register-file write must match the next expected retirement in order.
   always @(negedge clock) begin
      if (!reset) begin
         for (int r = 0; r < 2; r++) begin
            if (rf_we[r] === 1'b1) begin
               logic [36:0] e;
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("[TB] FAIL unexpected_retire port %0d: got reg %0d data %0h, expected none",
                           r, rf_waddr[r], rf_wdata[r]);
               end else begin
                  e = exp_q.pop_front();
                  if ({rf_waddr[r], rf_wdata[r]} !== e) begin
                     miscompares++;
                     $display("[TB] FAIL retire port %0d: got reg %0d data %0h, expected reg %0d data %0h",
                              r, rf_waddr[r], rf_wdata[r], e[36:32], e[31:0]);
                  end
               end
            end
         end
      end
   end

   initial begin
      doReset();
      checkOutput("reset_rob_full", 64'(rob_full), 64'd0);
      checkOutput("reset_rf_we", 64'(rf_we), 64'd0);

      // Four-slot allocation from empty, then fill to the full threshold.
      applyStimulus(4, {5'd4, 5'd3, 5'd2, 5'd1}, 4'hF, 4'd0);
      checkOutput("tail_after_4", 64'(reserved_slots[0]), 64'd4);
      checkOutput("not_full_4", 64'(rob_full), 64'd0);
      applyStimulus(4, {5'd8, 5'd7, 5'd6, 5'd5}, 4'hF, 4'd4);
      applyStimulus(4, {5'd12, 5'd11, 5'd10, 5'd9}, 4'hF, 4'd8);
      checkOutput("not_full_12", 64'(rob_full), 64'd0);
      applyStimulus(1, {5'd0, 5'd0, 5'd0, 5'd13}, 4'h1, 4'd12);
      checkOutput("full_13", 64'(rob_full), 64'd1);
      applyStimulus(1, {5'd0, 5'd0, 5'd0, 5'd30}, 4'h1, 4'd13);
      checkOutput("full_ignored_tail", 64'(reserved_slots[0]), 64'd13);
      checkOutput("full_ignored_flag", 64'(rob_full), 64'd1);
      expectRetire(5'd1, 32'h1111_0000);
      wb1(4'd0, 32'h1111_0000);
      checkOutput("full_before_retire", 64'(rob_full), 64'd1);
      tick();
      checkOutput("not_full_after_retire", 64'(rob_full), 64'd0);
      tick();

      // Out-of-order completion, in-order dual retire.
      doReset();
      applyStimulus(3, {5'd0, 5'd7, 5'd6, 5'd5}, 4'b0111, 4'd0);
      expectRetire(5'd5, 32'hD000_0000);
      expectRetire(5'd6, 32'hD000_0001);
      expectRetire(5'd7, 32'hD000_0002);
      wb1(4'd2, 32'hD000_0002);
      checkOutput("ooo_no_retire_a", 64'(rf_we), 64'd0);
      wb1(4'd1, 32'hD000_0001);
      checkOutput("ooo_no_retire_b", 64'(rf_we), 64'd0);
      tick();
      checkOutput("ooo_no_retire_c", 64'(rf_we), 64'd0);
      wb1(4'd0, 32'hD000_0000);
      checkOutput("ooo_latency", 64'(rf_we), 64'd0);
      tick();
      checkOutput("ooo_dual_retire", 64'(rf_we), 64'd3);
      tick();
      checkOutput("ooo_third_retire", 64'(rf_we), 64'd1);
      tick();
      checkOutput("ooo_idle", 64'(rf_we), 64'd0);

      // Move head/tail to 14, then allocate across the wrap point.
      doReset();
      applyStimulus(4, {5'd4, 5'd3, 5'd2, 5'd1}, 4'hF, 4'd0);
      applyStimulus(4, {5'd8, 5'd7, 5'd6, 5'd5}, 4'hF, 4'd4);
      applyStimulus(4, {5'd12, 5'd11, 5'd10, 5'd9}, 4'hF, 4'd8);
      applyStimulus(2, {5'd0, 5'd0, 5'd14, 5'd13}, 4'hF, 4'd12);
      for (int s = 0; s < 14; s += 2) begin
         expectRetire(5'(s + 1), 32'hC000_0000 + 32'(s));
         expectRetire(5'(s + 2), 32'hC000_0000 + 32'(s + 1));
         wb2(4'(s), 32'hC000_0000 + 32'(s), 4'(s + 1), 32'hC000_0000 + 32'(s + 1));
      end
      repeat (8) tick();
      applyStimulus(4, {5'd20, 5'd19, 5'd18, 5'd17}, 4'hF, 4'd14);
      expectRetire(5'd17, 32'hE000_000E);
      expectRetire(5'd18, 32'hE000_000F);
      expectRetire(5'd19, 32'hE000_0000);
      expectRetire(5'd20, 32'hE000_0001);
      wb2(4'd14, 32'hE000_000E, 4'd15, 32'hE000_000F);
      wb2(4'd0, 32'hE000_0000, 4'd1, 32'hE000_0001);
      checkOutput("wrap_retire_a", 64'(rf_we), 64'd3);
      tick();
      checkOutput("wrap_retire_b", 64'(rf_we), 64'd3);
      tick();
      checkOutput("wrap_idle", 64'(rf_we), 64'd0);
      applyStimulus(1, {5'd0, 5'd0, 5'd0, 5'd21}, 4'h1, 4'd2);
      expectRetire(5'd21, 32'hF000_0002);
      wb1(4'd2, 32'hF000_0002);
      repeat (3) tick();

      // No-dest entry, writeback to free slot, same-slot port conflict.
      applyStimulus(2, {5'd0, 5'd0, 5'd10, 5'd9}, 4'b0010, 4'd3);
      wb1(4'd6, 32'hBAD0_0006);
      expectRetire(5'd10, 32'h0A00_0004);
      wb2(4'd3, 32'h0A00_0003, 4'd4, 32'h0A00_0004);
      tick();
      checkOutput("nodest_retire", 64'(rf_we), 64'd2);
      tick();
      checkOutput("nodest_idle", 64'(rf_we), 64'd0);
      applyStimulus(2, {5'd0, 5'd0, 5'd12, 5'd11}, 4'b0011, 4'd5);
      expectRetire(5'd11, 32'h5151_0001);
      wb2(4'd5, 32'h5151_0000, 4'd5, 32'h5151_0001);
      tick();
      checkOutput("port1_wins_retire", 64'(rf_we), 64'd1);
      tick();
      checkOutput("free_wb_ignored_a", 64'(rf_we), 64'd0);
      tick();
      checkOutput("free_wb_ignored_b", 64'(rf_we), 64'd0);

      // Flush together with reserve and writeback.
      reserve       = 1'b1;
      reserve_count = 2'd3;
      dest_reg      = {5'd25, 5'd24, 5'd23, 5'd22};
      dest_reg_valid = 4'hF;
      wb_valid      = 2'b01;
      wb_slot[0]    = 4'd6;
      wb_data[0]    = 32'hFEED_0006;
      flush         = 1'b1;
      tick();
      idle();
      checkOutput("flush_rf_we", 64'(rf_we), 64'd0);
      checkOutput("flush_rob_full", 64'(rob_full), 64'd0);
      checkOutput("flush_slots", 64'(reserved_slots), 64'h3210);
      wb1(4'd6, 32'hFEED_1006);
      wb1(4'd0, 32'hFEED_1000);
      repeat (3) tick();
      checkOutput("flush_no_retire", 64'(rf_we), 64'd0);
      applyStimulus(4, {5'd4, 5'd3, 5'd2, 5'd1}, 4'hF, 4'd0);
      applyStimulus(4, {5'd8, 5'd7, 5'd6, 5'd5}, 4'hF, 4'd4);
      applyStimulus(4, {5'd12, 5'd11, 5'd10, 5'd9}, 4'hF, 4'd8);
      checkOutput("flush_count_12", 64'(rob_full), 64'd0);
      applyStimulus(1, {5'd0, 5'd0, 5'd0, 5'd13}, 4'h1, 4'd12);
      checkOutput("flush_count_13", 64'(rob_full), 64'd1);
      repeat (2) tick();

      checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
